// File: rtl/cpu_pkg.sv
// Shared constants for the small CPU datapath slice:
// opcodes, memory-address select codes and IR field widths.
package cpu_pkg;

  localparam int OP_W  = 2;
  localparam int SEL_W = 3;

  localparam logic [OP_W-1:0] OP_SUM = 2'b00;
  localparam logic [OP_W-1:0] OP_RES = 2'b01;
  localparam logic [OP_W-1:0] OP_MOV = 2'b10;
  localparam logic [OP_W-1:0] OP_OUT = 2'b11;

  localparam logic [SEL_W-1:0] SEL_PC  = 3'd0;
  localparam logic [SEL_W-1:0] SEL_A   = 3'd1;
  localparam logic [SEL_W-1:0] SEL_B   = 3'd2;
  localparam logic [SEL_W-1:0] SEL_DST = 3'd3;

  // Instruction is opcode followed by two AW-wide operand fields.
  function automatic int instr_w(input int aw);
    return OP_W + 2 * aw;
  endfunction

  function automatic int fld_a_lsb(input int aw);
    return aw;
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: SUM/RES with carry-borrow and zero,
// MOV/OUT pass operand a straight through.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [OP_W-1:0] op,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic [DW-1:0]   result,
  output logic            carry,
  output logic            zero
);

  logic [DW:0] wide;

  always_comb begin
    wide   = '0;
    result = a;
    carry  = 1'b0;
    unique case (1'b1)
      (op == OP_SUM): begin
        wide   = {1'b0, a} + {1'b0, b};
        result = wide[DW-1:0];
        carry  = wide[DW];
      end
      (op == OP_RES): begin
        // Top bit of the widened difference is the borrow.
        wide   = {1'b0, a} - {1'b0, b};
        result = wide[DW-1:0];
        carry  = wide[DW];
      end
      (op == OP_MOV),
      (op == OP_OUT): begin
        result = a;
      end
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/cpu_datapath.sv
// Datapath under the control FSM: PC, IR, operand regs,
// ALU, flags, data memory and the output port register.
module cpu_datapath
  import cpu_pkg::*;
#(
  parameter  int DW  = 8,
  parameter  int AW  = 4,
  parameter  int PAW = 6,
  localparam int IW  = 2 + 2 * AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IW-1:0]    instr_data,
  input  logic             enir,
  input  logic             enrop1,
  input  logic             enrop2,
  input  logic             enmem,
  input  logic             enrio,
  input  logic             enpc,
  input  logic [SEL_W-1:0] selmux,
  input  logic             ld_en,
  input  logic [AW-1:0]    ld_addr,
  input  logic [DW-1:0]    ld_data,
  output logic [PAW-1:0]   pc_addr,
  output logic [OP_W-1:0]  operacion,
  output logic [DW-1:0]    out_data,
  output logic             out_valid,
  output logic             flag_c,
  output logic             flag_z
);

  localparam int DEPTH = 2 ** AW;

  logic [PAW-1:0] pc_q, pc_d;
  logic [IW-1:0]  ir_q, ir_d;
  logic [DW-1:0]  rop1_q, rop1_d;
  logic [DW-1:0]  rop2_q, rop2_d;
  logic [DW-1:0]  out_q, out_d;
  logic           outv_q, outv_d;
  logic           fc_q, fc_d;
  logic           fz_q, fz_d;
  logic [DW-1:0]  mem_q [DEPTH];
  logic [DW-1:0]  mem_d [DEPTH];

  logic [OP_W-1:0] opcode;
  logic [AW-1:0]   fld_a;
  logic [AW-1:0]   fld_b;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   rd_data;
  logic [DW-1:0]   alu_res;
  logic            alu_c;
  logic            alu_z;

  assign opcode = ir_q[IW-1:IW-OP_W];
  assign fld_a  = ir_q[2*AW-1:AW];
  assign fld_b  = ir_q[AW-1:0];

  always_comb begin
    addr = '0;
    unique case (selmux)
      SEL_A:   addr = fld_a;
      SEL_B:   addr = fld_b;
      SEL_DST: addr = fld_a;
      default: addr = '0;
    endcase
  end

  // Read is combinational from the current array, so a
  // same-cycle write is seen only after the edge.
  assign rd_data = mem_q[addr];

  cpu_alu #(
    .DW(DW)
  ) u_alu (
    .op    (opcode),
    .a     (rop1_q),
    .b     (rop2_q),
    .result(alu_res),
    .carry (alu_c),
    .zero  (alu_z)
  );

  always_comb begin
    pc_d   = pc_q;
    ir_d   = ir_q;
    rop1_d = rop1_q;
    rop2_d = rop2_q;
    out_d  = out_q;
    outv_d = enrio;
    fc_d   = fc_q;
    fz_d   = fz_q;
    mem_d  = mem_q;
    if (enpc)   pc_d   = pc_q + 1'b1;
    if (enir)   ir_d   = instr_data;
    if (enrop1) rop1_d = rd_data;
    if (enrop2) rop2_d = rd_data;
    if (enrio)  out_d  = rd_data;
    if (enmem) begin
      mem_d[addr] = alu_res;
      if (opcode == OP_SUM || opcode == OP_RES) begin
        fc_d = alu_c;
        fz_d = alu_z;
      end
    end else if (ld_en) begin
      mem_d[ld_addr] = ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= '0;
      ir_q   <= '0;
      rop1_q <= '0;
      rop2_q <= '0;
      out_q  <= '0;
      outv_q <= 1'b0;
      fc_q   <= 1'b0;
      fz_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      pc_q   <= pc_d;
      ir_q   <= ir_d;
      rop1_q <= rop1_d;
      rop2_q <= rop2_d;
      out_q  <= out_d;
      outv_q <= outv_d;
      fc_q   <= fc_d;
      fz_q   <= fz_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign pc_addr   = pc_q;
  assign operacion = opcode;
  assign out_data  = out_q;
  assign out_valid = outv_q;
  assign flag_c    = fc_q;
  assign flag_z    = fz_q;

endmodule

// File: tb/tb_cpu_datapath.sv
// Randomized bench for cpu_datapath against an
// instruction-level memory/flag/pc model.
module tb_cpu_datapath;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] instr_data;
  logic       enir, enrop1, enrop2, enmem, enrio, enpc;
  logic [2:0] selmux;
  logic       ld_en;
  logic [3:0] ld_addr;
  logic [7:0] ld_data;
  logic [5:0] pc_addr;
  logic [1:0] operacion;
  logic [7:0] out_data;
  logic       out_valid, flag_c, flag_z;

  logic [9:0] rom [64];
  assign instr_data = rom[pc_addr];

  cpu_datapath dut (
    .clk(clk), .rst(rst), .instr_data(instr_data),
    .enir(enir), .enrop1(enrop1), .enrop2(enrop2),
    .enmem(enmem), .enrio(enrio), .enpc(enpc),
    .selmux(selmux), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data), .pc_addr(pc_addr),
    .operacion(operacion), .out_data(out_data),
    .out_valid(out_valid), .flag_c(flag_c), .flag_z(flag_z)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] m_mem [16];
  logic [5:0] m_pc;
  logic       m_c, m_z;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    enir = 0; enrop1 = 0; enrop2 = 0; enmem = 0;
    enrio = 0; enpc = 0; selmux = 0; ld_en = 0;
    ld_addr = 0; ld_data = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    m_pc = 0; m_c = 0; m_z = 0;
  endtask

  task automatic preload(input logic [3:0] a, input logic [7:0] d);
    ld_en = 1; ld_addr = a; ld_data = d;
    step();
    idle();
    m_mem[a] = d;
  endtask

  // Observe a memory word through an OUT-style read.
  task automatic chk_mem(input logic [3:0] a);
    logic [3:0] z;
    z = 4'h0;
    rom[m_pc] = {2'b11, a, z};
    enir = 1;
    step();
    idle();
    enrio = 1; selmux = 1;
    step();
    idle();
    chk($sformatf("mem[%0d]", a), {24'h0, out_data}, {24'h0, m_mem[a]});
    step();
  endtask

  task automatic exec(input logic [1:0] op, input logic [3:0] a,
                      input logic [3:0] b, input bit collide);
    logic [7:0] x, y, r;
    int s;
    x = m_mem[a];
    y = m_mem[b];
    rom[m_pc] = {op, a, b};
    enir = 1;
    step();
    idle();
    step();
    if (op == 2'b00 || op == 2'b01) begin
      enrop1 = 1; selmux = 1; step(); idle();
      enrop2 = 1; selmux = 2; step(); idle();
      enmem = 1; selmux = 3;
      if (collide) begin
        ld_en = 1; ld_addr = a; ld_data = ~x;
      end
      step(); idle();
      if (op == 2'b00) begin
        s = int'(x) + int'(y);
        r = s[7:0];
        m_c = (s > 255);
      end else begin
        r = x - y;
        m_c = (x < y);
      end
      m_z = (r == 8'h00);
      m_mem[a] = r;
    end else if (op == 2'b10) begin
      enrop1 = 1; selmux = 1; step(); idle();
      enmem = 1; selmux = 2; step(); idle();
      m_mem[b] = x;
    end else begin
      enrio = 1; selmux = 1; step(); idle();
      chk("out_valid_hi", {31'h0, out_valid}, 32'h1);
      chk("out_data", {24'h0, out_data}, {24'h0, x});
      step();
      chk("out_valid_lo", {31'h0, out_valid}, 32'h0);
    end
    enpc = 1; step(); idle();
    m_pc = m_pc + 6'd1;
    chk("pc", {26'h0, pc_addr}, {26'h0, m_pc});
    chk("flag_c", {31'h0, flag_c}, {31'h0, m_c});
    chk("flag_z", {31'h0, flag_z}, {31'h0, m_z});
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 10'h0;
    idle();
    model_reset();
    rst = 1;
    step(); step();
    chk("rst_pc", {26'h0, pc_addr}, 32'h0);
    chk("rst_op", {30'h0, operacion}, 32'h0);
    chk("rst_ov", {31'h0, out_valid}, 32'h0);
    chk("rst_c", {31'h0, flag_c}, 32'h0);
    chk("rst_z", {31'h0, flag_z}, 32'h0);
    rst = 0;
    for (int i = 0; i < 16; i++) chk_mem(4'(i));

    preload(4'd1, 8'h05); preload(4'd2, 8'h0A);
    exec(2'b00, 4'd1, 4'd2, 0);
    chk("sum_m1", {24'h0, m_mem[1]}, 32'h0F);
    chk_mem(4'd1);

    preload(4'd3, 8'h03); preload(4'd4, 8'h05);
    exec(2'b01, 4'd3, 4'd4, 0);
    chk_mem(4'd3);
    preload(4'd7, 8'h09); preload(4'd8, 8'h09);
    exec(2'b01, 4'd7, 4'd8, 0);
    chk_mem(4'd7);

    preload(4'd5, 8'h7A);
    exec(2'b10, 4'd5, 4'd6, 0);
    chk_mem(4'd6);
    exec(2'b11, 4'd6, 4'd0, 0);

    preload(4'd9, 8'h40); preload(4'd10, 8'hC5);
    exec(2'b00, 4'd9, 4'd10, 1);
    chk_mem(4'd9);

    // enmem and enrop1 on the same address: rop1 keeps the old word
    preload(4'd11, 8'h21); preload(4'd12, 8'h13);
    rom[m_pc] = {2'b00, 4'd11, 4'd12};
    enir = 1; step(); idle();
    enrop1 = 1; selmux = 1; step(); idle();
    enrop2 = 1; selmux = 2; step(); idle();
    enmem = 1; enrop1 = 1; selmux = 3; step(); idle();
    m_mem[12] = m_mem[11];
    m_mem[11] = 8'h34;
    m_c = 0; m_z = 0;
    rom[m_pc] = {2'b10, 4'd11, 4'd12};
    enir = 1; step(); idle();
    enmem = 1; selmux = 2; step(); idle();
    chk_mem(4'd11);
    chk_mem(4'd12);
    chk("wr_rd_c", {31'h0, flag_c}, {31'h0, m_c});

    for (int it = 0; it < 40; it++) begin
      logic [3:0] a, b;
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) preload(a, 8'($urandom));
      if ($urandom_range(0, 1) == 1) preload(b, 8'($urandom));
      exec(2'($urandom_range(0, 3)), a, b, 1'($urandom_range(0, 1)));
      chk_mem(a);
      chk_mem(b);
    end

    // enir and enpc together: IR takes the old-PC word
    rom[m_pc] = 10'b01_0000_0000;
    rom[m_pc + 6'd1] = 10'b10_0000_0000;
    enir = 1; enpc = 1; step(); idle();
    m_pc = m_pc + 6'd1;
    chk("ir_old_pc", {30'h0, operacion}, 32'h1);
    chk("pc_inc", {26'h0, pc_addr}, {26'h0, m_pc});

    rst = 1; step(); rst = 0;
    model_reset();
    enpc = 1;
    for (int i = 0; i < 63; i++) step();
    idle();
    chk("pc63", {26'h0, pc_addr}, 32'd63);
    enpc = 1; step(); idle();
    chk("pc_wrap", {26'h0, pc_addr}, 32'd0);

    // Reset in the middle of an instruction
    preload(4'd9, 8'h33); preload(4'd10, 8'h11);
    enpc = 1; step(); idle();
    rom[1] = {2'b00, 4'd9, 4'd10};
    enir = 1; step(); idle();
    step();
    enrop1 = 1; selmux = 1; step(); idle();
    enrop2 = 1; selmux = 2; rst = 1; step(); idle();
    rst = 0;
    model_reset();
    chk("mid_pc", {26'h0, pc_addr}, 32'h0);
    chk("mid_op", {30'h0, operacion}, 32'h0);
    preload(4'd0, 8'h21);
    enmem = 1; selmux = 3; step(); idle();
    m_mem[0] = 8'h00;
    chk("mid_rop_z", {31'h0, flag_z}, 32'h1);
    chk("mid_rop_c", {31'h0, flag_c}, 32'h0);
    chk_mem(4'd0);
    chk_mem(4'd9);
    chk_mem(4'd10);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
